lsu_load_mux: RTL and testbench
===============================

// Module: lsu_load_mux
// PURPOSE
//  Parametrised load-return path of the LSU (MEM stage): selects one of NUM_SRC load sources
//  (data memory, output periph, input periph, ...). Unlike a flat combinational mux it handshakes
//  a load request, waits for variable-latency source valid, aligns/extends byte/half/word and
//  returns one registered response with an error flag. Sits between LSU address decode and WB.
// PARAMETERS
//  NUM_SRC      4   number of load sources (>=2)
//  SEL_W        $clog2(NUM_SRC)  width of source select (derived, do not override)
//  DEFAULT_SRC  0   source used when req_sel_i >= NUM_SRC (data memory)
//  TIMEOUT      16  WAIT-cycle limit when LSU_LDMUX_TIMEOUT_EN is defined (>=2)
// PORTS
//  clk_i           in   1            clock, all state on rising edge
//  rst_i           in   1            synchronous active-high reset
//  req_valid_i     in   1            load request valid
//  req_ready_o     out  1            request accepted when valid&ready
//  req_sel_i       in   SEL_W        source select from address decode
//  req_off_i       in   2            byte offset addr[1:0]
//  req_size_i      in   2            00 byte, 01 half, 10 word, 11 illegal
//  req_uns_i       in   1            1 = zero-extend (LBU/LHU)
//  src_valid_i     in   NUM_SRC      per-source read-data valid (single-cycle pulse)
//  src_data_i      in   NUM_SRC*32   packed source data, src k at [32k+31:32k]
//  ld_valid_o      out  1            response valid, 1-cycle pulse
//  ld_data_o       out  32           aligned/extended load data (0 on error)
//  ld_err_o        out  1            misaligned/illegal size (or timeout), qualified by ld_valid_o
//  busy_o          out  1            1 while a load is outstanding (state != IDLE)
// BEHAVIOUR
//  - FSM IDLE/WAIT/RESP. Reset: state=IDLE, ld_valid_o=0, ld_data_o=0, ld_err_o=0, busy_o=0.
//  - req_ready_o=1 in IDLE and RESP, 0 in WAIT (RESP accepts next load: back-to-back).
//  - Accept: latch sel (out of range -> DEFAULT_SRC), off, size, uns. Misaligned (half off[0]=1,
//    word off!=0) or size=11 -> go RESP, err=1, data=0, no source wait. Else -> WAIT.
//  - WAIT: src_valid_i[sel_q]=1 -> register aligned data -> RESP. Other sources' valid ignored;
//    any src_valid_i in IDLE/RESP ignored. Min latency: accept cycle N, src valid N+1, ld_valid N+2.
//  - Align: byte = data[8*off +:8], half = data[16*off[1] +:16]; sign-extend unless uns; word as is.
//  - RESP: ld_valid_o=1 one cycle; ld_data_o/ld_err_o held until next RESP; -> WAIT/RESP on new
//    accept, else IDLE.
//  - rst_i mid-WAIT: request dropped, no response, all outputs to reset values next edge.
// CONFIGURATION
//  LSU_LDMUX_TIMEOUT_EN defined: WAIT counter (width $clog2(TIMEOUT)), cleared on entry; if no
//    selected valid after TIMEOUT WAIT cycles -> RESP with err=1, data=0. Valid on same cycle as
//    limit wins (normal response).
//  Not defined: no counter, WAIT holds indefinitely until selected valid.
// STRUCTURE
//  lsu_ldmux_pkg: state_e {IDLE,WAIT,RESP}, size_e {SZ_B,SZ_H,SZ_W}, XLEN=32.
//  Sub-module ld_align_ext (combinational: data, off, size, uns -> 32-bit result, misalign flag);
//  reused by store-side checker later.
// TESTING
//  1 LW sel=0, src0 data 0xDEADBEEF valid 1 cycle later -> ld_valid 2 cycles after accept,
//    data 0xDEADBEEF, err 0.
//  2 LB off=3 sel=2, data 0x80123456 -> 0xFFFFFF80; LBU same -> 0x00000080; LH off=2 -> 0xFFFF8012.
//  3 LW off=1 -> ld_valid next cycle after accept, err=1, data 0, sources never consulted.
//  4 sel=5 (NUM_SRC=4), src0 valid 0x11 -> data 0x11 via DEFAULT_SRC; src1 valid during WAIT ignored.
//  5 TIMEOUT_EN, TIMEOUT=16, no valid -> err=1 after 16 WAIT cycles; without macro busy_o stays 1.
//  6 rst_i during WAIT, then src valid -> no ld_valid, outputs 0; back-to-back accept in RESP works.

Source files
------------

// File: rtl/lsu_load_mux_pkg.sv
// Shared types for the LSU load-return path.
//   state_e : load FSM states
//   size_e  : load access size encoding (2'b11 is illegal and has no member)
//   XLEN    : data path width
package lsu_ldmux_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;
endpackage

// File: rtl/lsu_load_mux_if.sv
// Bus bundle between LSU address decode / load sources and the load mux.
//   req_*  : load request handshake and attributes
//   src_*  : per-source read-data valid pulses and packed data (src k at [32k+31:32k])
//   ld_*   : registered load response
//   busy_o : a load is outstanding
// slave modport is used by lsu_load_mux, master by its driver.
interface lsu_load_mux_if #(
    parameter int NUM_SRC = 4
);
    localparam int SEL_W = $clog2(NUM_SRC);

    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [SEL_W-1:0]        req_sel_i;
    logic [1:0]              req_off_i;
    logic [1:0]              req_size_i;
    logic                    req_uns_i;
    logic [NUM_SRC-1:0]      src_valid_i;
    logic [NUM_SRC*32-1:0]   src_data_i;
    logic                    ld_valid_o;
    logic [31:0]             ld_data_o;
    logic                    ld_err_o;
    logic                    busy_o;

    modport slave (
        input  req_valid_i, req_sel_i, req_off_i, req_size_i, req_uns_i,
        input  src_valid_i, src_data_i,
        output req_ready_o, ld_valid_o, ld_data_o, ld_err_o, busy_o
    );

    modport master (
        output req_valid_i, req_sel_i, req_off_i, req_size_i, req_uns_i,
        output src_valid_i, src_data_i,
        input  req_ready_o, ld_valid_o, ld_data_o, ld_err_o, busy_o
    );
endinterface

// File: rtl/lsu_load_mux_ld_align_ext.sv
// ld_align_ext: combinational load alignment and extension.
//   data     : raw 32-bit source word
//   off      : byte offset addr[1:0]
//   size     : 00 byte, 01 half, 10 word, 11 illegal
//   uns      : 1 = zero-extend
//   result   : aligned/extended value, 0 when misaligned
//   misalign : half with off[0]=1, word with off!=0, or illegal size
module ld_align_ext
    import lsu_ldmux_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      off,
    input  logic [1:0]      size,
    input  logic            uns,
    output logic [XLEN-1:0] result,
    output logic            misalign
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        result   = '0;
        misalign = 1'b0;
        b        = data[{off, 3'b000} +: 8];
        h        = data[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_B: result = {{24{~uns & b[7]}}, b};
            SZ_H: begin
                misalign = off[0];
                result   = {{16{~uns & h[15]}}, h};
            end
            SZ_W: begin
                misalign = (off != 2'b00);
                result   = data;
            end
            default: misalign = 1'b1;
        endcase
        if (misalign) result = '0;
    end
endmodule

// File: rtl/lsu_load_mux.sv
// lsu_load_mux: MEM-stage load-return path. Accepts one load request, waits for
// the selected variable-latency source, aligns/extends the data and returns a
// single registered response with an error flag.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : request handshake, source valid/data, response, busy
// Parameters: NUM_SRC sources, DEFAULT_SRC used for out-of-range selects,
// TIMEOUT WAIT-cycle limit.
// Optional feature macro: LSU_LDMUX_TIMEOUT_EN -- when defined, a load whose
// source never answers is terminated with err=1 after TIMEOUT WAIT cycles;
// when undefined, WAIT holds until the selected source answers.
module lsu_load_mux
    import lsu_ldmux_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int DEFAULT_SRC = 0,
    parameter int TIMEOUT     = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    lsu_load_mux_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_SRC);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_in;
    logic [1:0]        off_q, size_q;
    logic              uns_q;
    logic [XLEN-1:0]   data_q, resp_data;
    logic              err_q, resp_err;
    logic              accept, cap_req, cap_resp, sel_vld, tmo;
    logic [1:0]        a_off, a_size;
    logic              a_uns, a_mis;
    logic [XLEN-1:0]   src_word, a_res;

    assign bus.req_ready_o = (state_q != WAIT);
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign sel_in          = (int'(bus.req_sel_i) < NUM_SRC) ? bus.req_sel_i : SEL_W'(DEFAULT_SRC);
    assign src_word        = bus.src_data_i[sel_q*XLEN +: XLEN];
    assign sel_vld         = bus.src_valid_i[sel_q];

    // One aligner serves both phases: in WAIT it formats the latched request's
    // data; elsewhere it only screens the incoming request for misalignment.
    assign a_off  = (state_q == WAIT) ? off_q  : bus.req_off_i;
    assign a_size = (state_q == WAIT) ? size_q : bus.req_size_i;
    assign a_uns  = (state_q == WAIT) ? uns_q  : bus.req_uns_i;

    ld_align_ext u_align (
        .data     (src_word),
        .off      (a_off),
        .size     (a_size),
        .uns      (a_uns),
        .result   (a_res),
        .misalign (a_mis)
    );

`ifdef LSU_LDMUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] cnt_q;

    // Counter sits at zero outside WAIT, so it is clear on every WAIT entry.
    always_ff @(posedge clk_i) begin
        if (rst_i)                 cnt_q <= '0;
        else if (state_q != WAIT)  cnt_q <= '0;
        else                       cnt_q <= cnt_q + 1'b1;
    end
    assign tmo = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cap_req   = 1'b0;
        cap_resp  = 1'b0;
        resp_data = '0;
        resp_err  = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    cap_req = 1'b1;
                    if (a_mis) begin
                        state_d  = RESP;
                        cap_resp = 1'b1;
                        resp_err = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // A source answer on the limit cycle takes priority over timeout.
                if (sel_vld) begin
                    state_d   = RESP;
                    cap_resp  = 1'b1;
                    resp_data = a_res;
                end else if (tmo) begin
                    state_d  = RESP;
                    cap_resp = 1'b1;
                    resp_err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cap_req) begin
                sel_q  <= sel_in;
                off_q  <= bus.req_off_i;
                size_q <= bus.req_size_i;
                uns_q  <= bus.req_uns_i;
            end
            if (cap_resp) begin
                data_q <= resp_data;
                err_q  <= resp_err;
            end
        end
    end

    assign bus.ld_valid_o = (state_q == RESP);
    assign bus.ld_data_o  = data_q;
    assign bus.ld_err_o   = err_q;
    assign bus.busy_o     = (state_q != IDLE);
endmodule

// File: tb/tb_lsu_load_mux.sv
module tb_lsu_load_mux;
    localparam int NS = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_load_mux_if #(.NUM_SRC(NS)) bus ();

    lsu_load_mux #(.NUM_SRC(NS), .DEFAULT_SRC(0), .TIMEOUT(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] prev_d = 32'h0;
    logic        prev_e = 1'b0;

    typedef struct {
        logic [2:0]  sel;
        logic [1:0]  off;
        logic [1:0]  size;
        logic        uns;
        int          lat;
        bit          b2b;
        logic [31:0] dat;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Reference: load semantics computed with shifts and masks on integers.
    function automatic void model(input logic [31:0] dat, input int off, input int size,
                                  input bit uns, output logic [31:0] res, output logic err);
        err = 1'b0;
        res = 32'h0;
        case (size)
            0: begin
                res = (dat >> (8 * off)) & 32'hFF;
                if (!uns && res >= 128) res = res + 32'hFFFF_FF00;
            end
            1: if (off % 2 != 0) err = 1'b1;
               else begin
                   res = (dat >> (16 * (off / 2))) & 32'hFFFF;
                   if (!uns && res >= 32768) res = res + 32'hFFFF_0000;
               end
            2: if (off != 0) err = 1'b1; else res = dat;
            default: err = 1'b1;
        endcase
    endfunction

    task automatic load(input logic [2:0] sel, input logic [1:0] off, input logic [1:0] size,
                        input logic uns, input int lat, input bit b2b, input logic [31:0] dat,
                        input logic [31:0] exp_d, input logic exp_e);
        int eff;
        logic [NS-1:0] noise;
        eff = (sel < NS) ? int'(sel) : 0;
        if (!b2b) begin
            @(negedge clk);
            chk("pulse_low", {31'b0, bus.ld_valid_o}, 32'd0);
            chk("data_hold", bus.ld_data_o, prev_d);
            chk("err_hold", {31'b0, bus.ld_err_o}, {31'b0, prev_e});
        end
        chk("req_ready", {31'b0, bus.req_ready_o}, 32'd1);
        bus.req_valid_i = 1'b1;
        bus.req_sel_i   = sel;
        bus.req_off_i   = off;
        bus.req_size_i  = size;
        bus.req_uns_i   = uns;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        if (!exp_e) begin
            chk("wait_ready0", {31'b0, bus.req_ready_o}, 32'd0);
            for (int i = 1; i < lat; i++) begin
                chk("wait_novalid", {31'b0, bus.ld_valid_o}, 32'd0);
                chk("wait_busy", {31'b0, bus.busy_o}, 32'd1);
                noise = NS'($urandom) & ~(NS'(1) << eff);
                bus.src_valid_i = noise;
                for (int k = 0; k < NS; k++) bus.src_data_i[32*k +: 32] = $urandom;
                @(negedge clk);
            end
            noise = NS'($urandom) & ~(NS'(1) << eff);
            bus.src_valid_i = noise | (NS'(1) << eff);
            for (int k = 0; k < NS; k++)
                bus.src_data_i[32*k +: 32] = (k == eff) ? dat : $urandom;
            @(negedge clk);
            bus.src_valid_i = '0;
        end
        chk("ld_valid", {31'b0, bus.ld_valid_o}, 32'd1);
        chk("ld_data", bus.ld_data_o, exp_d);
        chk("ld_err", {31'b0, bus.ld_err_o}, {31'b0, exp_e});
        prev_d = exp_d;
        prev_e = exp_e;
    endtask

    vec_t vt[12];

    initial begin
        logic [31:0] md, rd;
        logic        me;
        bit          stuck;

        bus.req_valid_i = 1'b0;
        bus.req_sel_i   = '0;
        bus.req_off_i   = '0;
        bus.req_size_i  = '0;
        bus.req_uns_i   = 1'b0;
        bus.src_valid_i = '0;
        bus.src_data_i  = '0;

        vt[0]  = '{3'd0, 2'd0, 2'd2, 1'b0, 1,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vt[1]  = '{3'd2, 2'd3, 2'd0, 1'b0, 2,  1'b1, 32'h80123456, 32'hFFFFFF80, 1'b0};
        vt[2]  = '{3'd2, 2'd3, 2'd0, 1'b1, 1,  1'b0, 32'h80123456, 32'h00000080, 1'b0};
        vt[3]  = '{3'd2, 2'd2, 2'd1, 1'b0, 3,  1'b1, 32'h80123456, 32'hFFFF8012, 1'b0};
        vt[4]  = '{3'd1, 2'd1, 2'd2, 1'b0, 1,  1'b0, 32'h12345678, 32'h00000000, 1'b1};
        vt[5]  = '{3'd5, 2'd0, 2'd2, 1'b0, 3,  1'b1, 32'h00000011, 32'h00000011, 1'b0};
        vt[6]  = '{3'd4, 2'd0, 2'd1, 1'b1, 1,  1'b0, 32'h1234ABCD, 32'h0000ABCD, 1'b0};
        vt[7]  = '{3'd3, 2'd1, 2'd0, 1'b0, 2,  1'b1, 32'h1234ABCD, 32'hFFFFFFAB, 1'b0};
        vt[8]  = '{3'd0, 2'd0, 2'd3, 1'b0, 1,  1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vt[9]  = '{3'd1, 2'd1, 2'd1, 1'b1, 1,  1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vt[10] = '{3'd6, 2'd2, 2'd0, 1'b1, 2,  1'b1, 32'h00FF0000, 32'h000000FF, 1'b0};
        vt[11] = '{3'd1, 2'd0, 2'd2, 1'b0, 16, 1'b0, 32'hA5A55A5A, 32'hA5A55A5A, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_valid", {31'b0, bus.ld_valid_o}, 32'd0);
        chk("rst_data", bus.ld_data_o, 32'd0);
        chk("rst_err", {31'b0, bus.ld_err_o}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy_o}, 32'd0);
        rst = 1'b0;

        // Source valid while idle must not start anything.
        bus.src_valid_i = '1;
        @(negedge clk);
        bus.src_valid_i = '0;
        chk("idle_src_ignored", {30'b0, bus.busy_o, bus.ld_valid_o}, 32'd0);

        foreach (vt[i])
            load(vt[i].sel, vt[i].off, vt[i].size, vt[i].uns, vt[i].lat, vt[i].b2b,
                 vt[i].dat, vt[i].exp_d, vt[i].exp_e);

        for (int n = 0; n < 200; n++) begin
            logic [2:0] s;
            logic [1:0] o, z;
            logic       u;
            s  = 3'($urandom_range(0, 7));
            o  = 2'($urandom_range(0, 3));
            z  = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            rd = $urandom;
            model(rd, int'(o), int'(z), u, md, me);
            load(s, o, z, u, $urandom_range(1, 4), bit'($urandom_range(0, 1)), rd, md, me);
        end

        // Reset while WAIT drops the load; a later source valid produces nothing.
        load(3'd3, 2'd0, 2'd2, 1'b0, 1, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_sel_i   = 3'd3;
        bus.req_off_i   = 2'd0;
        bus.req_size_i  = 2'd2;
        bus.req_uns_i   = 1'b0;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.src_valid_i = NS'(1) << 3;
        bus.src_data_i[96 +: 32] = 32'h55555555;
        chk("rstw_valid", {31'b0, bus.ld_valid_o}, 32'd0);
        chk("rstw_data", bus.ld_data_o, 32'd0);
        chk("rstw_err", {31'b0, bus.ld_err_o}, 32'd0);
        chk("rstw_busy", {31'b0, bus.busy_o}, 32'd0);
        @(negedge clk);
        bus.src_valid_i = '0;
        chk("rstw_no_resp", {30'b0, bus.busy_o, bus.ld_valid_o}, 32'd0);
        prev_d = 32'h0;
        prev_e = 1'b0;

        // Source that never answers.
        load(3'd2, 2'd1, 2'd2, 1'b0, 1, 1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_sel_i   = 3'd1;
        bus.req_off_i   = 2'd0;
        bus.req_size_i  = 2'd2;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        stuck = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (bus.ld_valid_o !== 1'b0 || bus.busy_o !== 1'b1) stuck = 1'b0;
            @(negedge clk);
        end
        chk("hang_before_limit", {31'b0, stuck}, 32'd1);
`ifdef LSU_LDMUX_TIMEOUT_EN
        chk("tmo_valid", {31'b0, bus.ld_valid_o}, 32'd1);
        chk("tmo_err", {31'b0, bus.ld_err_o}, 32'd1);
        chk("tmo_data", bus.ld_data_o, 32'd0);
        @(negedge clk);
        chk("tmo_idle", {31'b0, bus.busy_o}, 32'd0);
`else
        for (int i = 0; i < 24; i++) begin
            if (bus.ld_valid_o !== 1'b0 || bus.busy_o !== 1'b1) stuck = 1'b0;
            @(negedge clk);
        end
        chk("hang_busy", {31'b0, stuck}, 32'd1);
        chk("hang_err_held", {31'b0, bus.ld_err_o}, 32'd1);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("final_idle", {31'b0, bus.busy_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end
endmodule
